sigmoid_arbiter: RTL and testbench
==================================

SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, sample width (signed Q8.8).
REQ-002 The block SHALL have parameter FRACT_WIDTH, default 8, fractional bits.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, number of requesters (power of two, 2..8).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock for all state.
REQ-005 The block SHALL have rst input 1: asynchronous active-high reset.
REQ-006 The block SHALL have req_valid input NUM_REQ: per-requester operand valid.
REQ-007 The block SHALL have req_data input NUM_REQ*DATA_WIDTH: packed signed operands, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have req_ready output NUM_REQ: one-hot-or-zero grant; requester i transfers when req_valid[i] & req_ready[i].
REQ-009 The block SHALL have out_valid output 1: result valid.
REQ-010 The block SHALL have out_data output DATA_WIDTH: unsigned Q8.8 sigmoid result.
REQ-011 The block SHALL have out_id output log2(NUM_REQ): index of the originating requester.
REQ-012 The block SHALL have out_ready input 1: downstream accepts result when out_valid & out_ready.
REQ-013 The block SHALL have acc_count output 16: total accepted operands, wraps 0xFFFF->0x0000.

Function
REQ-014 Shared function SHALL be hard sigmoid in Q8.8: x < -0x0200 -> 0x0000; x > 0x0200 -> 0x0100; otherwise (x + 0x0200) arithmetic-shifted right by 2.
REQ-015 Boundary values SHALL be: x=-0x0200 -> 0x0000, x=0x0000 -> 0x0080, x=0x0200 -> 0x0100, x=0x7FFF -> 0x0100, x=0x8000 -> 0x0000.
REQ-016 Pipeline SHALL be two registered stages: S1 (operand, id, valid), S2 (result, id, valid = out_valid); out_* driven directly from S2 registers.
REQ-017 S2 SHALL load from S1 when S2 empty or out_ready=1 (s2_adv); S1 SHALL load when S1 empty or s2_adv (s1_adv).
REQ-018 req_ready SHALL be zero for all requesters when s1_adv=0; at most one bit of req_ready SHALL be high in any cycle.
REQ-019 Grant SHALL be round-robin: search starts at pointer rr_ptr, first i (modulo NUM_REQ) with req_valid[i]=1 is granted; req_ready may depend combinationally on req_valid.
REQ-020 On a transfer from requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no transfer rr_ptr SHALL hold.
REQ-021 If s1_adv=1 and no request is valid, S1 SHALL become empty (valid 0) while S1 contents move to S2.
REQ-022 Latency SHALL be exactly 2 cycles from transfer edge to out_valid=1 when out_ready is held 1; sustained throughput SHALL be 1 result per cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_id SHALL be held stable; no result SHALL be dropped or duplicated.
REQ-024 Results SHALL emerge in acceptance order; each result SHALL carry the id granted at acceptance.
REQ-025 acc_count SHALL increment by 1 on each transfer cycle, independent of output stalls.
REQ-026 A requester holding req_valid=1 SHALL be granted within NUM_REQ transfer opportunities (no starvation).

Reset
REQ-027 While rst=1, S1/S2 valid, out_valid, out_data, out_id, rr_ptr and acc_count SHALL be 0, and req_ready SHALL be all 0.
REQ-028 Assertion of rst mid-operation SHALL immediately discard all in-flight operands; no result from before reset SHALL appear after release.
REQ-029 The first grant after reset release SHALL search from requester 0.

Verification
REQ-030 Single op: req 2 valid x=0x0000, out_ready=1 -> req_ready=0b0100, two cycles later out_valid=1, out_data=0x0080, out_id=2, acc_count=1.
REQ-031 Clamp sweep via req 0: x=0xFC00,0xFE00,0xFF00,0x0100,0x0200,0x0300 -> outputs 0x0000,0x0000,0x0040,0x00C0,0x0100,0x0100 in order, back-to-back.
REQ-032 All four requesters valid continuously, out_ready=1 -> grant order 0,1,2,3,0,...; out_id sequence matches; one result per cycle.
REQ-033 Backpressure: fill pipeline, drop out_ready for 3 cycles -> out_data/out_id stable, req_ready all 0 once S1 and S2 full, no loss after out_ready returns.
REQ-034 Reset mid-stream with 2 ops in flight -> out_valid=0, acc_count=0 immediately; after release req 3 alone valid x=0x0200 -> out_data=0x0100, out_id=3, no stale results.
REQ-035 Counter wrap: 65536 transfers -> acc_count returns to 0x0000.

Source files
------------

// File: rtl/sigmoid_arbiter_if.sv
// Handshake bundle between the requesters, the sigmoid arbiter and the result consumer.
//   req_valid / req_data / req_ready : per-requester operand handshake
//                                      (requester i occupies req_data[i*DATA_WIDTH +: DATA_WIDTH])
//   out_valid / out_data / out_id / out_ready : result handshake, out_id names the source requester
//   acc_count : running count of accepted operands (16-bit, wraps)
// The master modport is the environment side; the slave modport is the arbiter itself.
interface sigmoid_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [ID_WIDTH-1:0]           out_id;
  logic                          out_ready;
  logic [15:0]                   acc_count;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, acc_count
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, acc_count
  );
endinterface

// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter feeding a shared two-stage hard-sigmoid pipeline (Q8.8 in, Q8.8 out).
//   clk : rising-edge clock for all state
//   rst : asynchronous active-high reset, discards everything in flight
//   bus : sigmoid_arbiter_if slave modport
//         req_* : NUM_REQ operand ports, one-hot-or-zero grant on req_ready
//         out_* : result port driven straight from the S2 registers
//         acc_count : number of accepted operands
module sigmoid_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int NUM_REQ     = 4
) (
  input  logic             clk,
  input  logic             rst,
  sigmoid_arbiter_if.slave bus
);

  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Knee of the hard sigmoid (2.0 in Q format) and the saturated output (1.0).
  localparam logic signed [DATA_WIDTH+1:0] KNEE = (DATA_WIDTH+2)'(2 << FRACT_WIDTH);
  localparam logic [DATA_WIDTH-1:0]        ONE  = DATA_WIDTH'(1 << FRACT_WIDTH);

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [ID_WIDTH-1:0]   s1_id;
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [ID_WIDTH-1:0]   s2_id;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [15:0]           acc_count;

  logic                  s2_adv;
  logic                  s1_adv;
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   idx;
  logic                  transfer;

  // Sign-extend by two bits so x + 2.0 cannot overflow for any input.
  function automatic logic [DATA_WIDTH-1:0] hard_sigmoid(input logic [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH+1:0] xe;
    logic signed [DATA_WIDTH+1:0] sum;
    logic [DATA_WIDTH-1:0]        result;
    xe  = $signed({{2{x[DATA_WIDTH-1]}}, x});
    sum = xe + KNEE;
    if (xe < -KNEE)
      result = '0;
    else if (xe > KNEE)
      result = ONE;
    else
      result = DATA_WIDTH'(sum >>> 2);
    return result;
  endfunction

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Pointer arithmetic wraps naturally because NUM_REQ is a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr + ID_WIDTH'(k);
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  // Gated by rst so no grant is advertised while the pipeline is held in reset.
  assign transfer      = grant_found && s1_adv && !rst;
  assign bus.req_ready = transfer ? (NUM_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_id     <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_id     <= '0;
      rr_ptr    <= '0;
      acc_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= transfer;
        if (transfer) begin
          s1_data   <= bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
          s1_id     <= grant_id;
          rr_ptr    <= grant_id + ID_WIDTH'(1);
          acc_count <= acc_count + 16'd1;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        s2_data  <= hard_sigmoid(s1_data);
        s2_id    <= s1_id;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_id    = s2_id;
  assign bus.acc_count = acc_count;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed self-checking bench for sigmoid_arbiter: reset state, single-op latency,
// clamp/boundary sweep, round-robin order with backpressure, mid-stream reset, counter wrap.
module tb_sigmoid_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sigmoid_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  sigmoid_arbiter #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected results in acceptance order: {id, data}
  logic [IW+DW-1:0] expQ[$];

  logic [DW-1:0] sweepIn  [8] = '{16'hFC00, 16'hFE00, 16'hFF00, 16'h0100,
                                  16'h0200, 16'h0300, 16'h7FFF, 16'h8000};
  logic [DW-1:0] sweepOut [8] = '{16'h0000, 16'h0000, 16'h0040, 16'h00C0,
                                  16'h0100, 16'h0100, 16'h0100, 16'h0000};

  logic [DW-1:0] heldData;
  logic [IW-1:0] heldId;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic setReq(input int i, input logic [DW-1:0] x);
    bus.req_data[i*DW +: DW] = x;
  endtask

  // Drive one cycle: apply inputs, check the grant, score any result handed over
  // at the coming edge, then step to just after that edge.
  task automatic applyStimulus(input logic [NR-1:0] valid, input logic ready,
                               input logic [NR-1:0] expReady, input string tag);
    logic [IW+DW-1:0] e;
    bus.req_valid = valid;
    bus.out_ready = ready;
    #1;
    checkOutput(tag, 32'(bus.req_ready), 32'(expReady));
    if (bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("stale_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_data", 32'(bus.out_data), 32'(e[DW-1:0]));
        checkOutput("out_id", 32'(bus.out_id), 32'(e[DW +: IW]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    bus.req_valid = '0;
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;

    // Reset state, with every requester asking so the grant gating is exercised.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_out_id", 32'(bus.out_id), 32'd0);
    checkOutput("rst_acc_count", 32'(bus.acc_count), 32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single operation from requester 2, x = 0.
    setReq(2, 16'h0000);
    expQ.push_back({2'd2, 16'h0080});
    applyStimulus(4'b0100, 1'b1, 4'b0100, "single_grant");
    checkOutput("single_lat1_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(4'b0000, 1'b1, 4'b0000, "single_idle1");
    checkOutput("single_lat2_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("single_acc", 32'(bus.acc_count), 32'd1);
    applyStimulus(4'b0000, 1'b1, 4'b0000, "single_idle2");
    checkOutput("single_done_valid", 32'(bus.out_valid), 32'd0);

    // Clamp and boundary sweep, back-to-back through requester 0.
    for (int c = 0; c < 8; c++) begin
      setReq(0, sweepIn[c]);
      expQ.push_back({2'd0, sweepOut[c]});
      applyStimulus(4'b0001, 1'b1, 4'b0001, "sweep_grant");
    end
    repeat (3) applyStimulus(4'b0000, 1'b1, 4'b0000, "sweep_drain_idle");
    checkOutput("sweep_drain", 32'(expQ.size()), 32'd0);
    checkOutput("sweep_acc", 32'(bus.acc_count), 32'd9);

    // Round-robin with all requesters valid, a 3-cycle stall, then resume.
    applyReset();
    for (int i = 0; i < NR; i++) setReq(i, 16'(i * 16'h0040));
    for (int c = 0; c < 19; c++) begin
      logic [NR-1:0] v;
      logic          r;
      logic [NR-1:0] er;
      int            g;
      v  = (c < 15) ? 4'hF : 4'h0;
      r  = (c >= 8 && c <= 10) ? 1'b0 : 1'b1;
      g  = -1;
      if (c < 8) g = c % 4;
      else if (c >= 11 && c < 15) g = (c - 11) % 4;
      er = (g >= 0) ? 4'(1 << g) : 4'h0;
      if (g >= 0) expQ.push_back({2'(g), 16'(16'h0080 + 16'h0010 * g)});
      if (c == 8) begin
        heldData = bus.out_data;
        heldId   = bus.out_id;
        checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
      end
      if (c == 9 || c == 10) begin
        checkOutput("stall_data_stable", 32'(bus.out_data), 32'(heldData));
        checkOutput("stall_id_stable", 32'(bus.out_id), 32'(heldId));
      end
      applyStimulus(v, r, er, "rr_grant");
    end
    checkOutput("rr_drain", 32'(expQ.size()), 32'd0);
    checkOutput("rr_acc", 32'(bus.acc_count), 32'd12);

    // Reset with two operations in flight.
    setReq(0, 16'h0000);
    setReq(1, 16'h0000);
    applyStimulus(4'hF, 1'b0, 4'b0001, "midrst_fill0");
    applyStimulus(4'hF, 1'b0, 4'b0010, "midrst_fill1");
    checkOutput("midrst_inflight_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_acc", 32'(bus.acc_count), 32'd0);
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    setReq(3, 16'h0200);
    expQ.push_back({2'd3, 16'h0100});
    applyStimulus(4'b1000, 1'b1, 4'b1000, "postrst_grant");
    repeat (3) applyStimulus(4'b0000, 1'b1, 4'b0000, "postrst_idle");
    checkOutput("postrst_drain", 32'(expQ.size()), 32'd0);
    checkOutput("postrst_acc", 32'(bus.acc_count), 32'd1);

    // Counter wrap after 65536 transfers.
    applyReset();
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    checkOutput("wrap_ffff", 32'(bus.acc_count), 32'h0000FFFF);
    @(posedge clk);
    #1;
    checkOutput("wrap_zero", 32'(bus.acc_count), 32'd0);
    bus.req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
